// File: rtl/path_feeder.sv
// Buffers one day of 12-bit path samples from a loader, then streams the day at one word per cycle.
// Latency: word 0 is on o_out_data two edges after the last load is accepted; a replay resend gives word 0 two edges later.
// Backpressure: the loader is stalled via o_load_ready outside FILL; the output stream has no backpressure.
// Build option: PATH_FEEDER_REPLAY_EN enables replay-then-advance resend handling; when undefined, every resend advances the day.
module path_feeder #(
  parameter int DATA_W   = 12,
  parameter int DAY_LEN  = 256,
  parameter int NUM_DAYS = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_load_valid,
  input  logic [DATA_W-1:0]           i_load_data,
  output logic                        o_load_ready,
  input  logic                        i_resend,
  output logic                        o_out_valid,
  output logic [DATA_W-1:0]           o_out_data,
  output logic [$clog2(NUM_DAYS)-1:0] o_day_idx,
  output logic                        o_done
);

  localparam int PTR_W = $clog2(DAY_LEN);
  localparam int DAY_W = $clog2(NUM_DAYS);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_HOLD, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_buf [DAY_LEN];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [DAY_W-1:0]    r_day_idx;
  logic                r_done;
  logic                r_p1_vld;
  logic [DATA_W-1:0]   r_p1_dat;
  logic                r_out_vld;
  logic [DATA_W-1:0]   r_out_dat;
`ifdef PATH_FEEDER_REPLAY_EN
  logic                r_res;
`endif

  logic w_start, w_accept, w_last_load, w_rs, w_replay, w_advance;
  logic w_last_day, w_issue, w_last_issue, w_to_done;

  // Decode handshakes from the current state; a resend always pre-empts a stream issue.
  always_comb begin
    w_start      = i_start & ((r_state == S_IDLE) | (r_state == S_DONE));
    w_accept     = i_load_valid & (r_state == S_FILL);
    w_last_load  = w_accept & (r_wr_ptr == PTR_W'(DAY_LEN - 1));
    w_rs         = i_resend & ((r_state == S_STREAM) | (r_state == S_HOLD));
`ifdef PATH_FEEDER_REPLAY_EN
    w_replay     = w_rs & ~r_res;
`else
    w_replay     = 1'b0;
`endif
    w_advance    = w_rs & ~w_replay;
    w_last_day   = (r_day_idx == DAY_W'(NUM_DAYS - 1));
    w_to_done    = w_advance & w_last_day;
    w_issue      = (r_state == S_STREAM) & ~w_rs;
    w_last_issue = w_issue & (r_rd_ptr == PTR_W'(DAY_LEN - 1));
  end

  // Next-state selection; resend decisions override the normal sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_FILL;
      S_FILL:   if (w_last_load) w_next = S_STREAM;
      S_STREAM: if (w_last_issue) w_next = S_HOLD;
      S_HOLD:   w_next = S_HOLD;
      S_DONE:   if (w_start) w_next = S_FILL;
      default:  w_next = S_IDLE;
    endcase
    if (w_replay) w_next = S_STREAM;
    if (w_advance) w_next = w_last_day ? S_DONE : S_FILL;
  end

  // State, pointers, day counter and the two-stage output pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_day_idx <= '0;
      r_done    <= 1'b0;
      r_p1_vld  <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
`ifdef PATH_FEEDER_REPLAY_EN
      r_res     <= 1'b0;
`endif
    end else begin
      r_state  <= w_next;
      r_p1_vld <= w_issue;
      if (w_start) begin
        r_day_idx <= '0;
        r_wr_ptr  <= '0;
        r_done    <= 1'b0;
`ifdef PATH_FEEDER_REPLAY_EN
        r_res     <= 1'b0;
`endif
      end
      if (w_accept)    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_last_load) r_rd_ptr <= '0;
      if (w_issue)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_replay) begin
        r_rd_ptr <= '0;
`ifdef PATH_FEEDER_REPLAY_EN
        r_res    <= 1'b1;
`endif
      end
      if (w_advance) begin
`ifdef PATH_FEEDER_REPLAY_EN
        r_res <= 1'b0;
`endif
        if (w_last_day) begin
          r_done <= 1'b1;
        end else begin
          r_day_idx <= r_day_idx + DAY_W'(1);
          r_wr_ptr  <= '0;
        end
      end
      // Going to DONE silences the output; otherwise the last word is held when the stream stops.
      if (w_to_done) begin
        r_out_vld <= 1'b0;
        r_out_dat <= '0;
      end else begin
        r_out_vld <= r_p1_vld;
        if (r_p1_vld) r_out_dat <= r_p1_dat;
      end
    end
  end

  // Sample buffer write port and registered read; contents need no reset since a day is always refilled before it streams.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_buf[r_wr_ptr] <= i_load_data;
    if (w_issue)  r_p1_dat <= r_buf[r_rd_ptr];
  end

  assign o_load_ready = (r_state == S_FILL);
  assign o_out_valid  = r_out_vld;
  assign o_out_data   = r_out_dat;
  assign o_day_idx    = r_day_idx;
  assign o_done       = r_done;

endmodule

// File: tb/tb_path_feeder.sv
module tb_path_feeder;
  localparam int DW = 12;
  localparam int DL = 256;
  localparam int ND = 64;

  logic          clk = 1'b0;
  logic          rst_n, start, load_valid, resend;
  logic [DW-1:0] load_data;
  logic          load_ready, out_valid, done;
  logic [DW-1:0] out_data;
  logic [5:0]    day_idx;

  always #5 clk = ~clk;

  path_feeder #(.DATA_W(DW), .DAY_LEN(DL), .NUM_DAYS(ND)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_load_valid(load_valid), .i_load_data(load_data), .o_load_ready(load_ready),
    .i_resend(resend), .o_out_valid(out_valid), .o_out_data(out_data),
    .o_day_idx(day_idx), .o_done(done)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] day_dat [DL];
  int n_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every live output word must be the next word the model expects.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %0d expected no word", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
      n_seen++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: a day streams as its loaded words in order; push the first n of them.
  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(day_dat[i]);
  endtask

  task automatic load_day(input bit gapped);
    int acc = 0;
    int cyc = 0;
    bit acc_now;
    while (acc < DL && cyc < 4 * DL) begin
      @(negedge clk);
      if (gapped && $urandom_range(0, 1) == 0) begin
        load_valid = 1'b0;
        load_data  = DW'($urandom);
      end else begin
        load_valid = 1'b1;
        load_data  = day_dat[acc];
      end
      acc_now = load_valid && load_ready;
      @(posedge clk);
      if (acc_now) acc++;
      cyc++;
    end
    check("load_count", acc, DL);
    // Loader keeps offering a garbage word while the feeder is not ready; it must be dropped.
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = DW'($urandom);
  endtask

  task automatic wait_valid(input string name, input int exp_k);
    int k = 0;
    while (out_valid !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check(name, k, exp_k);
  endtask

  task automatic count_valid(input string name, input int exp_n);
    int n = 0;
    while (out_valid === 1'b1 && n < DL + 8) begin
      @(negedge clk);
      n++;
    end
    check(name, n, exp_n);
  endtask

  task automatic pulse_resend();
    load_valid = 1'b0;
    resend = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resend = 1'b0;
  endtask

  task automatic pulse_start();
    load_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full pass after a fill (or after a replay resend): word 0 two edges on, DAY_LEN words, last word held.
  task automatic full_pass(input string tag);
    wait_valid({tag, "_latency"}, 2);
    count_valid({tag, "_length"}, DL);
    check({tag, "_hold_data"}, out_data, day_dat[DL-1]);
    check({tag, "_hold_ready"}, load_ready, 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic advance(input int new_day);
    pulse_resend();
    check("adv_ready", load_ready, 1);
    check("adv_day", day_idx, new_day);
    check("adv_done", done, 0);
  endtask

  // One day: fill, stream, then (with replay) replay and advance.
  task automatic run_day(input int d, input bit gapped);
    for (int i = 0; i < DL; i++) day_dat[i] = DW'($urandom);
    push_words(DL);
    load_day(gapped);
    full_pass("stream");
`ifdef PATH_FEEDER_REPLAY_EN
    push_words(DL);
    pulse_resend();
    check("replay_day", day_idx, d);
    check("replay_ready", load_ready, 0);
    full_pass("replay");
`endif
    if (d < ND - 1) begin
      advance(d + 1);
    end else begin
      pulse_resend();
      check("last_done", done, 1);
      check("last_day_idx", day_idx, ND - 1);
      check("last_ready", load_ready, 0);
      check("last_valid", out_valid, 0);
    end
  endtask

  initial begin
    int bound;
    rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; resend = 1'b0; load_data = '0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ready", load_ready, 0);
    check("rst_day", day_idx, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Resend in IDLE does nothing.
    pulse_resend();
    check("idle_resend_ready", load_ready, 0);
    check("idle_resend_valid", out_valid, 0);
    pulse_start();
    check("start_ready", load_ready, 1);
    check("start_day", day_idx, 0);

    // Day 0: counting pattern, back-to-back load.
    for (int i = 0; i < DL; i++) day_dat[i] = DW'(i);
    push_words(DL);
    load_day(1'b0);
    full_pass("count");
    check("count_hold_ff", out_data, 12'h0FF);
`ifdef PATH_FEEDER_REPLAY_EN
    push_words(DL);
    pulse_resend();
    check("count_replay_day", day_idx, 0);
    full_pass("count_replay");
`endif
    advance(1);

    // Day 1: gapped load, resend aborts the pass at word 100.
    for (int i = 0; i < DL; i++) day_dat[i] = DW'($urandom);
    n_seen = 0;
    push_words(101);
    load_day(1'b1);
    bound = 0;
    while (n_seen < 100 && bound < 400) begin
      @(negedge clk);
      #1;
      bound++;
    end
    check("abort_reached", n_seen, 100);
`ifdef PATH_FEEDER_REPLAY_EN
    push_words(DL);
    pulse_resend();
    @(negedge clk);
    check("abort_gap", out_valid, 0);
    wait_valid("abort_restart", 1);
    count_valid("abort_replay_len", DL);
    check("abort_queue", exp_q.size(), 0);
    advance(2);
`else
    pulse_resend();
    check("abort_adv_ready", load_ready, 1);
    check("abort_adv_day", day_idx, 2);
    @(negedge clk);
    check("abort_gap", out_valid, 0);
    check("abort_queue", exp_q.size(), 0);
`endif

    // Remaining days with random data and random load gaps.
    for (int d = 2; d < ND; d++) run_day(d, 1'b1);

    // DONE: resend ignored, start restarts at day 0.
    pulse_resend();
    check("done_sticky", done, 1);
    check("done_ready", load_ready, 0);
    pulse_start();
    check("restart_done", done, 0);
    check("restart_day", day_idx, 0);
    check("restart_ready", load_ready, 1);

    // Stream day 0 and advance, then reset in the middle of day 1's stream.
    run_day(0, 1'b0);
    for (int i = 0; i < DL; i++) day_dat[i] = DW'($urandom_range(1, 4095));
    n_seen = 0;
    push_words(DL);
    load_day(1'b0);
    bound = 0;
    while (n_seen < 20 && bound < 100) begin
      @(negedge clk);
      #1;
      bound++;
    end
    check("mid_reset_streaming", out_valid, 1);
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ready", load_ready, 0);
    check("mid_rst_day", day_idx, 0);
    check("mid_rst_done", done, 0);
    exp_q.delete();
    @(negedge clk);
    start = 1'b0;
    load_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", load_ready, 0);
    pulse_resend();
    check("post_rst_resend_ready", load_ready, 0);
    check("post_rst_resend_day", day_idx, 0);
    pulse_start();
    check("post_rst_start", load_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/path_feeder.md
# path_feeder

Upstream stage of `Top` for the S_PRICING phase. It buffers one day of simulated path samples (12-bit, 8.4 unsigned fixed point) from a loader port, then streams them into `Top.in` at one word per cycle. It honours `Top`'s `resend` handshake: the first resend replays the same day for the regression pass, the second advances to the next day. It replaces the testbench-side path sequencing with synthesizable logic.

## Interface
- `DATA_W`, 12, sample width (8 integer + 4 fraction bits)
- `DAY_LEN`, 256, samples per day (power of two)
- `NUM_DAYS`, 64, days per pricing run
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse; begins a run from day 0 (honoured in IDLE and DONE only)
- `load_valid`  in  1  loader word present
- `load_data`  in  DATA_W  loader sample
- `load_ready`  out  1  feeder accepts a word this cycle
- `resend`  in  1  one-cycle request from `Top`
- `out_valid`  out  1  `out_data` is a live sample; drives `Top` in pricing
- `out_data`  out  DATA_W  sample to `Top.in`
- `day_idx`  out  clog2(NUM_DAYS)  current day
- `done`  out  1  all days consumed; sticky

## Operation
- Storage: `DAY_LEN` x `DATA_W` buffer, write pointer `wr_ptr`, read pointer `rd_ptr` (both clog2(DAY_LEN) bits), replay flag `res`.
- States:
  - IDLE: `start` -> FILL, with `day_idx`=0, `res`=0, `wr_ptr`=0.
  - FILL: `load_ready`=1. Each `load_valid & load_ready` writes `buf[wr_ptr]` and increments `wr_ptr`. On acceptance of word `DAY_LEN-1` -> STREAM, with `rd_ptr`=0.
  - STREAM: registered read `out_data <= buf[rd_ptr]`, `rd_ptr++`. No backpressure. After word `DAY_LEN-1` is issued -> HOLD.
  - HOLD: `out_valid`=0 and `out_data` holds the last word; wait for `resend`.
  - DONE: `done`=1 and all outputs are quiet; `start` clears `done` -> FILL at day 0.
- Resend, sampled in STREAM or HOLD. In STREAM it aborts the current pass.
  - `res`=0: set `res`=1, `rd_ptr`=0, -> STREAM. This is the replay; the buffer is unchanged.
  - `res`=1: clear `res`.
    - If `day_idx`==NUM_DAYS-1: -> DONE.
    - Otherwise: `day_idx++`, `wr_ptr`=0, -> FILL.
- `resend` in IDLE, FILL or DONE is ignored. `start` outside IDLE and DONE is ignored.
- `load_valid` while `load_ready`=0 is dropped; the loader must hold the word.
- Pointers wrap naturally at `DAY_LEN`. No arithmetic is performed on samples; data passes bit-exact.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `load_ready`=0, `day_idx`=0, `done`=0; state IDLE.
- Buffer contents are not reset and are never output before being refilled.
- Fill-to-stream: last word accepted at edge N; word 0 appears on `out_data` with `out_valid`=1 after edge N+2. It stays valid for exactly `DAY_LEN` consecutive cycles; `out_valid` falls after edge N+DAY_LEN+2.
- Resend sampled at edge R (replay case): word 0 is valid after edge R+2; `out_valid` is 0 after edge R+1.
- Resend sampled at edge R (advance case): `load_ready`=1 and the new `day_idx` are visible after edge R.
- Resend on the same edge as the last STREAM word: the resend wins and that word is not output.
- Async reset mid-operation clears all outputs immediately, with no clock needed; after release the block waits in IDLE for `start`.

## Configuration
- `PATH_FEEDER_REPLAY_EN` defined: two-resend protocol as above, with replay then advance.
- Not defined: `res` is removed, and every `resend` behaves as the advance case, for single-pass pricing.

## Test plan
- Reset: assert `rst_n`=0 mid-clock -> all outputs 0 at once; `start` ignored until release; `resend` in IDLE -> no change.
- Fill/stream: `start`, load 0x000..0x0FF back-to-back -> `out_data` 0x000..0x0FF on 256 consecutive cycles beginning 2 edges after the last load, then `out_valid`=0 and `out_data`=0x0FF held.
- Gapped load: toggle `load_valid` every other cycle -> still exactly 256 words accepted; stream order unchanged.
- Resend protocol (macro on): first `resend` in HOLD -> replay of 0x000..0x0FF with `day_idx`=0; second `resend` -> `load_ready`=1 and `day_idx`=1. Resend at stream word 100 -> restart at 0x000.
- Full run: 64 days each loaded with value day*4 -> last advance resend sets `done`=1 and `day_idx`=63; `start` -> `done`=0, `day_idx`=0.
- Macro off: single `resend` in HOLD -> `day_idx` advances to 1 with no replay.
